// File: rtl/fp_pkg.sv
// Shared widths, constants and enums for the iterative single-precision divider
// and its rounding stage.
package fp_pkg;
   localparam int N    = 32;
   localparam int ES   = 8;
   localparam int M    = N - ES - 1;
   localparam int BIAS = 2**(ES-1) - 1;
   localparam int EW   = ES + 2;          // signed working exponent
   localparam int QW   = M + 4;           // quotient bits: 24 + guard + round + one spare
   localparam int RW   = M + 2;           // partial remainder width
   localparam int CW   = $clog2(M + 3);

   localparam logic [N-1:0] QNAN = {1'b0, {ES{1'b1}}, 1'b1, {(M-1){1'b0}}};
   localparam logic [N-2:0] INF  = {{ES{1'b1}}, {M{1'b0}}};

   localparam int F_INVALID = 4;
   localparam int F_DIVZ    = 3;
   localparam int F_OVF     = 2;
   localparam int F_UNF     = 1;
   localparam int F_INX     = 0;

   typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, DONE} state_t;

   typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_DIVZ, SP_INF, SP_ZERO} special_t;
endpackage

// File: rtl/fp_div_round.sv
// Combinational back end: normalize raw quotient, round to nearest even,
// range-check the exponent (flush-to-zero) and build the flag vector.
module fp_div_round
   import fp_pkg::*;
(
   input  logic                 sign,
   input  special_t             special,
   input  logic signed [EW-1:0] exp_in,
   input  logic [QW-1:0]        q,
   input  logic                 rem_nz,
   output logic [N-1:0]         r,
   output logic [4:0]           flags
);
   localparam logic signed [EW-1:0] ONE_E  = EW'(1);
   localparam logic signed [EW-1:0] ZERO_E = '0;
   localparam logic signed [EW-1:0] E_TOP  = EW'(2**ES - 1);

   logic [QW-1:0]        qn;
   logic signed [EW-1:0] e1, e2;
   logic [M:0]           mant, mant_r;
   logic [M+1:0]         sum;
   logic                 guard, rnd, sticky, up, inexact;

   always_comb begin
      qn      = q[QW-1] ? q : (q << 1);
      e1      = q[QW-1] ? exp_in : (exp_in - ONE_E);
      mant    = qn[QW-1 -: M+1];
      guard   = qn[2];
      rnd     = qn[1];
      sticky  = qn[0] | rem_nz;
      up      = guard & (rnd | sticky | mant[0]);
      inexact = guard | rnd | sticky;
      sum     = {1'b0, mant} + {{(M+1){1'b0}}, up};
      // carry out of the mantissa means it rounded up to exactly 2.0
      if (sum[M+1]) begin
         mant_r = sum[M+1:1];
         e2     = e1 + ONE_E;
      end else begin
         mant_r = sum[M:0];
         e2     = e1;
      end

      r     = '0;
      flags = '0;
      case (special)
         SP_NAN: begin
            r                = QNAN;
            flags[F_INVALID] = 1'b1;
         end
         SP_DIVZ: begin
            r             = {sign, INF};
            flags[F_DIVZ] = 1'b1;
         end
         SP_INF:  r = {sign, INF};
         SP_ZERO: r = {sign, {(N-1){1'b0}}};
         default: begin
            if (e2 >= E_TOP) begin
               r            = {sign, INF};
               flags[F_OVF] = 1'b1;
               flags[F_INX] = 1'b1;
            end else if (e2 <= ZERO_E) begin
               r            = {sign, {(N-1){1'b0}}};
               flags[F_UNF] = 1'b1;
               flags[F_INX] = 1'b1;
            end else begin
               r            = {sign, e2[ES-1:0], mant_r[M-1:0]};
               flags[F_INX] = inexact;
            end
         end
      endcase
   end
endmodule

// File: rtl/fp_div_32b_iter.sv
// Iterative IEEE-754 single-precision divider: restoring radix-2, one quotient
// bit per clock, fixed 29-clock latency from accept to out_valid.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   PREP  | unpack latched operands, classify, seed remainder/divisor/exponent
//   DIV   | one restoring step per clock, 27 quotient bits
//   ROUND | register normalized/rounded result and flags
//   DONE  | out_valid held until out_ready
module fp_div_32b_iter
   import fp_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] r,
   output logic [4:0]   flags
);
   localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);

   state_t               state, state_nxt;
   logic [N-1:0]         a_q, b_q;
   logic [CW-1:0]        cnt;
   logic [RW-1:0]        rem, rem_nxt;
   logic [M:0]           dvs;
   logic [QW-1:0]        q;
   logic signed [EW-1:0] exp_r, exp_prep;
   logic                 sign_r, ge;
   special_t             spec_r, spec_nxt;
   logic [ES-1:0]        ea, eb;
   logic [M-1:0]         fa, fb;
   logic                 a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
   logic [N-1:0]         r_rnd;
   logic [4:0]           flags_rnd;

   assign ea = a_q[N-2:M];
   assign eb = b_q[N-2:M];
   assign fa = a_q[M-1:0];
   assign fb = b_q[M-1:0];

   // exponent field of zero covers subnormals too: they are flushed to zero
   assign a_nan  = (&ea) & (|fa);
   assign a_inf  = (&ea) & ~(|fa);
   assign a_zero = ~(|ea);
   assign b_nan  = (&eb) & (|fb);
   assign b_inf  = (&eb) & ~(|fb);
   assign b_zero = ~(|eb);

   assign exp_prep = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;

   assign ge      = rem >= {1'b0, dvs};
   assign rem_nxt = (ge ? (rem - {1'b0, dvs}) : rem) << 1;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_comb begin
      spec_nxt = SP_NONE;
      if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf))
         spec_nxt = SP_NAN;
      else if (b_zero & ~a_inf)
         spec_nxt = SP_DIVZ;
      else if (a_inf)
         spec_nxt = SP_INF;
      else if (b_inf | a_zero)
         spec_nxt = SP_ZERO;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = PREP;
         PREP:    state_nxt = DIV;
         DIV:     if (cnt == '0) state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         cnt    <= '0;
         rem    <= '0;
         dvs    <= '0;
         q      <= '0;
         exp_r  <= '0;
         sign_r <= 1'b0;
         spec_r <= SP_NONE;
         r      <= '0;
         flags  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q <= a;
                  b_q <= b;
               end
            end
            PREP: begin
               rem    <= {2'b01, fa};
               dvs    <= {1'b1, fb};
               q      <= '0;
               exp_r  <= exp_prep;
               sign_r <= a_q[N-1] ^ b_q[N-1];
               spec_r <= spec_nxt;
               cnt    <= CW'(QW - 1);
            end
            DIV: begin
               q   <= {q[QW-2:0], ge};
               rem <= rem_nxt;
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            ROUND: begin
               r     <= r_rnd;
               flags <= flags_rnd;
            end
            default: ;
         endcase
      end
   end

   fp_div_round u_round (
      .sign    (sign_r),
      .special (spec_r),
      .exp_in  (exp_r),
      .q       (q),
      .rem_nz  (|rem),
      .r       (r_rnd),
      .flags   (flags_rnd)
   );
endmodule

// File: tb/tb_fp_div_32b_iter.sv
// Scoreboard bench for fp_div_32b_iter: directed IEEE cases plus random normal
// operands checked against an exact big-integer quotient model with RNE/FTZ.
module tb_fp_div_32b_iter;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] r;
   logic [4:0]  flags;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [36:0] exp_next;
   logic [36:0] exp_q[$];
   int          acc_q[$];
   bit          mon_en = 0;
   bit          prev_ov = 0;
   logic [31:0] hold_r;
   logic [4:0]  hold_f;

   fp_div_32b_iter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r         (r),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endfunction

   // Exact quotient with 60 extra fraction bits plus remainder, rounded to nearest even.
   function automatic logic [36:0] ref_div(input logic [31:0] x, input logic [31:0] y);
      logic [7:0]   ex, ey;
      logic [22:0]  fx, fy;
      logic         s;
      logic [127:0] num, den, qq, rr, low, half, one;
      logic [24:0]  mant;
      int           e, sh;
      bit           xn, xi, xz, yn, yi, yz, inx;
      ex = x[30:23]; fx = x[22:0];
      ey = y[30:23]; fy = y[22:0];
      s  = x[31] ^ y[31];
      xn = (ex == 8'hFF) && (fx != 0); xi = (ex == 8'hFF) && (fx == 0); xz = (ex == 0);
      yn = (ey == 8'hFF) && (fy != 0); yi = (ey == 8'hFF) && (fy == 0); yz = (ey == 0);
      if (xn || yn || (xz && yz) || (xi && yi)) return {5'b10000, 32'h7FC0_0000};
      if (yz && !xi) return {5'b01000, s, 8'hFF, 23'd0};
      if (xi) return {5'b00000, s, 8'hFF, 23'd0};
      if (yi || xz) return {5'b00000, s, 31'd0};
      one = 128'd1;
      num = {104'd0, 1'b1, fx} << 60;
      den = {104'd0, 1'b1, fy};
      qq  = num / den;
      rr  = num % den;
      if (qq[60]) begin
         e = int'(ex) - int'(ey) + 127; sh = 37;
      end else begin
         e = int'(ex) - int'(ey) + 126; sh = 36;
      end
      mant = 25'(qq >> sh);
      low  = qq & ((one << sh) - one);
      half = one << (sh - 1);
      inx  = (low != 0) || (rr != 0);
      if ((low > half) || ((low == half) && ((rr != 0) || mant[0]))) mant = mant + 25'd1;
      if (mant[24]) begin
         mant = mant >> 1;
         e    = e + 1;
      end
      if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
      if (e <= 0)   return {5'b00011, s, 31'd0};
      return {4'b0000, inx, s, e[7:0], mant[22:0]};
   endfunction

   function automatic logic [31:0] rand_normal();
      logic [7:0] e;
      if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(1, 254));
      else                           e = 8'($urandom_range(87, 167));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   // Accept tracking: expected result is queued on the edge that takes the operands.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
      end else if (in_valid && in_ready) begin
         exp_q.push_back(exp_next);
         acc_q.push_back(cyc);
      end
   end

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (out_valid) begin
            if (!prev_ov) begin
               if (acc_q.size() == 0) chk("unexpected_out_valid", 1, 0);
               else chk("latency", cyc - acc_q.pop_front(), 29);
            end else begin
               chk("hold_r", r, hold_r);
               chk("hold_flags", flags, hold_f);
            end
            chk("in_ready_in_done", in_ready, 0);
            if (out_ready) begin
               if (exp_q.size() == 0) chk("result_without_request", 1, 0);
               else begin
                  logic [36:0] e;
                  e = exp_q.pop_front();
                  chk("r", r, e[31:0]);
                  chk("flags", flags, e[36:32]);
               end
            end
         end
         prev_ov = out_valid && !out_ready;
         hold_r  = r;
         hold_f  = flags;
      end else begin
         prev_ov = 0;
      end
   end

   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [36:0] e);
      int budget;
      @(posedge clk); #1;
      a = x; b = y; exp_next = e; in_valid = 1;
      budget = 0;
      while (!in_ready && budget < 100) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 1, 0);
         in_valid = 0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 0;
      a = $urandom; b = $urandom;
   endtask

   task automatic drain(input bit bp);
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 400) begin
         out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(posedge clk); #1;
         budget++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
      out_ready = 1;
   endtask

   logic [31:0] dir_a [12];
   logic [31:0] dir_b [12];
   logic [31:0] dir_r [12];
   logic [4:0]  dir_f [12];

   initial begin
      dir_a = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h7F800000, 32'hC0000000,
                32'h7F7FFFFF, 32'h00800000, 32'h7F800001, 32'h00000001, 32'hFF800000, 32'h3F800000};
      dir_b = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F800000,
                32'h3F000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h80000000};
      dir_r = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
                32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h00000000, 32'hFF800000, 32'hFF800000};
      dir_f = '{5'b00000, 5'b00001, 5'b01000, 5'b10000, 5'b10000, 5'b00000,
                5'b00101, 5'b00011, 5'b10000, 5'b00000, 5'b00000, 5'b01000};

      rst = 1; in_valid = 0; out_ready = 1; a = 0; b = 0; exp_next = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_r", r, 0);
      chk("reset_flags", flags, 0);
      rst = 0;
      mon_en = 1;

      for (int i = 0; i < 12; i++) begin
         issue(dir_a[i], dir_b[i], {dir_f[i], dir_r[i]});
         drain(0);
      end

      // backpressure: hold result for 10 clocks while extra operands are offered
      out_ready = 0;
      issue(32'h40C00000, 32'h40000000, {5'b00000, 32'h40400000});
      begin
         int budget;
         budget = 0;
         while (!out_valid && budget < 60) begin
            @(posedge clk); #1;
            budget++;
         end
         chk("bp_out_valid_seen", out_valid, 1);
      end
      a = 32'h3F800000; b = 32'h40400000; exp_next = '1; in_valid = 1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      in_valid = 0;
      drain(0);
      repeat (40) @(posedge clk);
      #1;
      chk("bp_extra_ignored", exp_q.size(), 0);

      // reset in the middle of DIV aborts the operation
      issue(32'h40C00000, 32'h40000000, {5'b00000, 32'h40400000});
      repeat (10) @(posedge clk);
      #1; rst = 1;
      @(posedge clk); #1;
      chk("midreset_in_ready", in_ready, 1);
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_r", r, 0);
      chk("midreset_flags", flags, 0);
      rst = 0;
      repeat (35) @(posedge clk);
      #1;
      chk("midreset_no_output", out_valid, 0);
      issue(32'h40C00000, 32'h40000000, {5'b00000, 32'h40400000});
      drain(0);

      for (int i = 0; i < 1200; i++) begin
         logic [31:0] x, y;
         x = rand_normal();
         y = rand_normal();
         issue(x, y, ref_div(x, y));
         drain(1);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("queue_empty_at_end", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
